// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/adjust sequencing and BCD MM:SS counters for the stopwatch.
// Buttons are synchronised and debounced; switches are synchronised only.
module stopwatch_ctrl #(
    parameter int DEBOUNCE_SAMPLES = 3,
    parameter int MAX_FIELD = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       tick_fast,
    input  logic       blink_phase,
    input  logic       rst_button,
    input  logic       pause_button,
    input  logic       adj_switch,
    input  logic       sel_switch,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       blank_min,
    output logic       blank_sec,
    output logic       running
);
    localparam logic [7:0] MAX_BCD = 8'(((MAX_FIELD / 10) << 4) | (MAX_FIELD % 10));

    typedef enum logic {RUN, PAUSED} state_t;

    state_t state;
    logic [1:0] rst_sync, pause_sync, adj_sync, sel_sync;
    logic [1:0] lvl, acc, acc_d, press;
    logic [1:0][3:0] cnt;
    logic adj, sel, rst_press, pause_press;

    assign adj = adj_sync[1];
    assign sel = sel_sync[1];
    assign lvl = {pause_sync[1], rst_sync[1]};
    assign press = acc & ~acc_d;
    assign rst_press = press[0];
    assign pause_press = press[1];

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return (v == MAX_BCD) ? 8'h00 :
               (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'h0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= '0;
            pause_sync <= '0;
            adj_sync <= '0;
            sel_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], rst_button};
            pause_sync <= {pause_sync[0], pause_button};
            adj_sync <= {adj_sync[0], adj_switch};
            sel_sync <= {sel_sync[0], sel_switch};
        end
    end

    // Accepted level flips only after DEBOUNCE_SAMPLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            acc <= '0;
            acc_d <= '0;
        end else begin
            acc_d <= acc;
            for (int b = 0; b < 2; b++) begin
                if (lvl[b] == acc[b]) cnt[b] <= '0;
                else if (tick_fast) begin
                    if (cnt[b] == 4'(DEBOUNCE_SAMPLES - 1)) begin
                        cnt[b] <= '0;
                        acc[b] <= lvl[b];
                    end else cnt[b] <= cnt[b] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            min_bcd <= 8'h00;
            sec_bcd <= 8'h00;
            running <= 1'b1;
            blank_min <= 1'b0;
            blank_sec <= 1'b0;
        end else begin
            blank_min <= adj & ~sel & blink_phase;
            blank_sec <= adj & sel & blink_phase;
            if (rst_press) begin
                state <= RUN;
                running <= 1'b1;
                min_bcd <= 8'h00;
                sec_bcd <= 8'h00;
            end else if (pause_press) begin
                state <= (state == RUN) ? PAUSED : RUN;
                running <= (state != RUN);
            end else if (state == RUN) begin
                if (!adj && tick_1hz) begin
                    sec_bcd <= bcd_inc(sec_bcd);
                    if (sec_bcd == MAX_BCD) min_bcd <= bcd_inc(min_bcd);
                end else if (adj && tick_2hz) begin
                    if (sel) sec_bcd <= bcd_inc(sec_bcd);
                    else min_bcd <= bcd_inc(min_bcd);
                end
            end
        end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: randomized and directed checks of stopwatch_ctrl against an integer MM:SS model.
module tb_stopwatch_ctrl;
    localparam int DEB = 3;
    localparam int MAX = 59;

    logic clk = 0, rst_n = 0, tick_1hz = 0, tick_2hz = 0, tick_fast = 0, blink_phase = 0;
    logic rst_button = 0, pause_button = 0, adj_switch = 0, sel_switch = 0;
    logic [7:0] min_bcd, sec_bcd;
    logic blank_min, blank_sec, running;
    int tests = 0, fails = 0;
    int m = 0, s = 0;
    bit run = 1, a = 0, sl = 0, illegal = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.DEBOUNCE_SAMPLES(DEB), .MAX_FIELD(MAX)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .tick_fast(tick_fast),
        .blink_phase(blink_phase), .rst_button(rst_button), .pause_button(pause_button),
        .adj_switch(adj_switch), .sel_switch(sel_switch), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .blank_min(blank_min), .blank_sec(blank_sec), .running(running)
    );

    always @(negedge clk)
        if (rst_n && (sec_bcd[3:0] > 4'd9 || sec_bcd > 8'h59 || min_bcd[3:0] > 4'd9 || min_bcd > 8'h59))
            illegal = 1;

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + v % 10);
    endfunction

    function automatic logic [16:0] expv();
        return {bcd(m), bcd(s), run};
    endfunction

    function automatic logic [16:0] obs();
        return {min_bcd, sec_bcd, running};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_tick(input bit t1, input bit t2);
        if (!run) return;
        if (!a && t1) begin
            s++;
            if (s > MAX) begin
                s = 0;
                m = (m + 1) % (MAX + 1);
            end
        end else if (a && t2) begin
            if (sl) s = (s + 1) % (MAX + 1);
            else m = (m + 1) % (MAX + 1);
        end
    endtask

    task automatic ticks(input bit t1, input bit t2, input int n);
        repeat (n) begin
            tick_1hz = t1;
            tick_2hz = t2;
            step();
            tick_1hz = 0;
            tick_2hz = 0;
            model_tick(t1, t2);
        end
    endtask

    task automatic set_sw(input bit na, input bit ns);
        a = na;
        sl = ns;
        adj_switch = na;
        sel_switch = ns;
        repeat (3) step();
    endtask

    // Hold for n fast samples, optionally firing tick_1hz on the cycle the press is acted upon, then release cleanly.
    task automatic press(input bit r, input bit p, input int n, input bit t1_at_accept);
        rst_button = r;
        pause_button = p;
        repeat (2) step();
        for (int i = 0; i < n; i++) begin
            tick_fast = 1;
            step();
            tick_fast = 0;
            tick_1hz = (i == DEB - 1) && t1_at_accept;
            step();
            tick_1hz = 0;
        end
        rst_button = 0;
        pause_button = 0;
        repeat (2) step();
        repeat (DEB + 1) begin
            tick_fast = 1;
            step();
            tick_fast = 0;
            step();
        end
    endtask

    task automatic clear_press();
        press(1, 0, DEB, 0);
        m = 0;
        s = 0;
        run = 1;
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if ({obs(), blank_min, blank_sec} !== {8'h00, 8'h00, 1'b1, 2'b00}) begin
            fails++;
            $display("FAIL reset_state: got %h required %h", {obs(), blank_min, blank_sec}, {8'h00, 8'h00, 1'b1, 2'b00});
        end
        #2 rst_n = 1;
        ticks(1, 0, 61);
        tests++;
        if (obs() !== {8'h01, 8'h01, 1'b1} || obs() !== expv()) begin
            fails++;
            $display("FAIL count_61: got %h required %h", obs(), {8'h01, 8'h01, 1'b1});
        end
    endtask

    task automatic test_preload();
        clear_press();
        set_sw(1, 0);
        ticks(0, 1, 59);
        set_sw(1, 1);
        ticks(0, 1, 58);
        tests++;
        if (obs() !== {8'h59, 8'h58, 1'b1}) begin
            fails++;
            $display("FAIL preload_5958: got %h required %h", obs(), {8'h59, 8'h58, 1'b1});
        end
        set_sw(0, 0);
        ticks(1, 0, 3);
        tests++;
        if (obs() !== {8'h00, 8'h01, 1'b1} || obs() !== expv()) begin
            fails++;
            $display("FAIL wrap_5959: got %h required %h", obs(), {8'h00, 8'h01, 1'b1});
        end
    endtask

    task automatic test_pause();
        press(0, 1, 5, 0);
        run = !run;
        tests++;
        if (obs() !== expv() || running !== 1'b0) begin
            fails++;
            $display("FAIL pause_hold: got %h required %h", obs(), expv());
        end
        ticks(1, 0, 10);
        tests++;
        if (obs() !== expv()) begin
            fails++;
            $display("FAIL paused_frozen: got %h required %h", obs(), expv());
        end
        press(0, 1, 5, 0);
        run = !run;
        ticks(1, 0, 1);
        tests++;
        if (obs() !== expv() || running !== 1'b1) begin
            fails++;
            $display("FAIL resume: got %h required %h", obs(), expv());
        end
    endtask

    task automatic test_adjust_wrap();
        clear_press();
        set_sw(1, 1);
        ticks(0, 1, 30);
        set_sw(1, 0);
        for (int i = 0; i < 60; i++) begin
            blink_phase = 1'($urandom);
            tick_2hz = 1;
            step();
            tick_2hz = 0;
            model_tick(0, 1);
            tests++;
            if (blank_min !== blink_phase || blank_sec !== 1'b0) begin
                fails++;
                $display("FAIL adj_blank: got %b%b required %b0", blank_min, blank_sec, blink_phase);
            end
        end
        blink_phase = 0;
        tests++;
        if (obs() !== {8'h00, 8'h30, 1'b1} || obs() !== expv()) begin
            fails++;
            $display("FAIL adj_min_wrap: got %h required %h", obs(), {8'h00, 8'h30, 1'b1});
        end
        set_sw(0, 0);
    endtask

    task automatic test_priority();
        press(0, 1, DEB, 1);
        run = 0;
        tests++;
        if (obs() !== expv()) begin
            fails++;
            $display("FAIL pause_beats_tick: got %h required %h", obs(), expv());
        end
        press(0, 1, DEB, 0);
        run = 1;
    endtask

    task automatic test_glitch_and_combo();
        press(0, 1, DEB - 1, 0);
        press(1, 0, DEB - 1, 0);
        tests++;
        if (obs() !== expv()) begin
            fails++;
            $display("FAIL glitch: got %h required %h", obs(), expv());
        end
        clear_press();
        set_sw(1, 0);
        ticks(0, 1, 12);
        set_sw(1, 1);
        ticks(0, 1, 34);
        set_sw(0, 0);
        press(0, 1, DEB, 0);
        run = 0;
        tests++;
        if (obs() !== {8'h12, 8'h34, 1'b0}) begin
            fails++;
            $display("FAIL paused_1234: got %h required %h", obs(), {8'h12, 8'h34, 1'b0});
        end
        press(1, 1, DEB, 0);
        m = 0;
        s = 0;
        run = 1;
        tests++;
        if (obs() !== {8'h00, 8'h00, 1'b1}) begin
            fails++;
            $display("FAIL rst_and_pause: got %h required %h", obs(), {8'h00, 8'h00, 1'b1});
        end
    endtask

    task automatic test_async_reset();
        clear_press();
        set_sw(1, 0);
        ticks(0, 1, 7);
        set_sw(1, 1);
        ticks(0, 1, 7);
        blink_phase = 1;
        step();
        tests++;
        if (obs() !== {8'h07, 8'h07, 1'b1} || blank_sec !== 1'b1) begin
            fails++;
            $display("FAIL pre_async: got %h/%b required %h/1", obs(), blank_sec, {8'h07, 8'h07, 1'b1});
        end
        pause_button = 1;
        repeat (2) step();
        repeat (DEB - 1) begin
            tick_fast = 1;
            step();
            tick_fast = 0;
        end
        #2 rst_n = 0;
        #1;
        tests++;
        if ({obs(), blank_min, blank_sec} !== {8'h00, 8'h00, 1'b1, 2'b00}) begin
            fails++;
            $display("FAIL async_reset: got %h required %h", {obs(), blank_min, blank_sec}, {8'h00, 8'h00, 1'b1, 2'b00});
        end
        pause_button = 0;
        blink_phase = 0;
        adj_switch = 0;
        sel_switch = 0;
        a = 0;
        sl = 0;
        m = 0;
        s = 0;
        run = 1;
        #10 rst_n = 1;
        repeat (3) step();
        repeat (DEB + 1) begin
            tick_fast = 1;
            step();
            tick_fast = 0;
        end
        ticks(1, 0, 2);
        tests++;
        if (obs() !== {8'h00, 8'h02, 1'b1}) begin
            fails++;
            $display("FAIL pending_press_dropped: got %h required %h", obs(), {8'h00, 8'h02, 1'b1});
        end
    endtask

    task automatic test_random();
        bit t1, t2;
        int r;
        set_sw(0, 0);
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) set_sw(1'($urandom), 1'($urandom));
            else if (r == 1) begin
                press(0, 1, int'($urandom_range(DEB, DEB + 3)), 0);
                run = !run;
            end else begin
                blink_phase = 1'($urandom);
                t1 = 1'($urandom);
                t2 = 1'($urandom);
                ticks(t1, t2, 1);
                tests++;
                if ({obs(), blank_min, blank_sec} !== {expv(), a & ~sl & blink_phase, a & sl & blink_phase}) begin
                    fails++;
                    $display("FAIL random_%0d: got %h required %h", i, {obs(), blank_min, blank_sec},
                             {expv(), a & ~sl & blink_phase, a & sl & blink_phase});
                end
            end
        end
        blink_phase = 0;
    endtask

    task automatic test_legal();
        tests++;
        if (illegal !== 1'b0) begin
            fails++;
            $display("FAIL legal_bcd: got illegal=%b required 0", illegal);
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_pause();
        test_adjust_wrap();
        test_priority();
        test_glitch_and_combo();
        test_async_reset();
        test_random();
        test_legal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
